fp_regfile_sb: RTL and testbench
================================

# fp_regfile_sb

Parametrised floating-point register file with an integrated scoreboard for the next-generation FPU pipeline. It has N read ports (three by default, for fused multiply-add rs3), M write-back ports (FPU result and FLW load), and per-register busy tracking. Decode uses busy tracking to stall on RAW/WAW hazards against multi-cycle FPU ops. It sits between the decode/issue stage and the write-back stage.

## Interface
- XLEN, 32, data width of each register
- NREGS, 32, number of registers; address width AW = $clog2(NREGS)
- NRD, 3, read ports
- NWR, 2, write ports; a higher index has higher priority
- HARDWIRE_ZERO, 1, when 1, reg 0 reads 0 and is never written or marked busy
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- rd_addr  input  NRD×AW  read addresses
- rd_data  output  NRD×XLEN  read data (combinational)
- rd_busy  output  NRD  busy bit of the addressed register (combinational)
- wb_en  input  NWR  write enables
- wb_addr  input  NWR×AW  write addresses
- wb_data  input  NWR×XLEN  write data
- iss_valid  input  1  issue request that claims a destination
- iss_rd  input  AW  destination being claimed
- iss_ready  output  1  claim accepted this cycle
- flush  input  1  clear all busy bits (pipeline flush)
- busy_vec  output  NREGS  full scoreboard, for debug/perf counters

## Operation
- Reset (rst_n low, async): all registers = 0; all busy bits = 0. Consequently rd_data = 0, rd_busy = 0, busy_vec = 0, and iss_ready = 1 whenever iss_valid is asserted.
- Write: on a rising edge with wb_en[k] set, reg[wb_addr[k]] <= wb_data[k], and busy[wb_addr[k]] is cleared.
- Same-address writes in one cycle: the highest port index wins the data. Busy is cleared once.
- Zero register: with HARDWIRE_ZERO=1, writes to reg 0 are dropped and issue to reg 0 is always ready with no busy set. With HARDWIRE_ZERO=0, reg 0 is an ordinary register.
- Issue handshake: iss_ready = !busy[iss_rd] || (any wb_en[k] with wb_addr[k]==iss_rd this cycle). A WAW stall occurs until the producer retires.
- On iss_valid && iss_ready, busy[iss_rd] is set at the next edge.
- Issue and write-back to the same register in the same cycle: set wins, so the register ends busy with the new data written.
- flush: all busy bits are cleared at the edge and register contents are kept. flush takes priority over a simultaneous issue set; that issue is dropped and the caller re-issues.
- Out-of-range addresses (NREGS not a power of two): reads return 0, writes and issue are ignored, and iss_ready = 1.

## Timing
- Read latency is 0 cycles (combinational from rd_addr and state).
- Write is visible on reads the cycle after the edge. Without bypass, a same-cycle read returns old data.
- Busy set/clear takes effect 1 cycle after the triggering edge. rd_busy reflects state before the edge.
- iss_ready depends combinationally on iss_rd, busy, wb_en and wb_addr. It has no dependence on iss_valid.

## Configuration
- FPRF_BYPASS_EN defined: a read whose address matches an active write this cycle returns the winning wb_data, and its rd_busy reads 0. This gives same-cycle write-to-read forwarding.
- FPRF_BYPASS_EN undefined: reads return stored contents only, and decode must wait one cycle after write-back.

## Structure
- Package fprf_pkg holds: default XLEN/NREGS constants, the AW localparam function, the typedef fp_reg_t (logic [XLEN-1:0]), and the typedef fp_addr_t.
- Sub-module fprf_scoreboard owns the busy vector, issue/clear/flush priority, and iss_ready. The top level holds the storage array, the read muxes and the bypass.

## Test plan
- Reset mid-operation: write reg 5 = 32'h3F800000 and issue reg 5, then pulse rst_n low between edges. Required: rd_data of reg 5 = 0, busy_vec = 0 immediately.
- Issue reg 7, then wb_en[0] reg 7 = 32'h40490FDB two cycles later. Required: rd_busy on reg 7 is 1 for cycles 1–2 and 0 afterwards; data = 32'h40490FDB.
- WAW stall: with reg 3 busy, iss_valid reg 3 gives iss_ready = 0. In the cycle of wb to reg 3, iss_ready = 1 and busy stays 1 afterwards.
- Dual write collision: wb port 0 writes reg 9 = 32'h1 and port 1 writes reg 9 = 32'h2 in the same cycle. Required: read gives 32'h2.
- Zero register: write reg 0 = 32'hDEADBEEF and issue reg 0. Required: reads 0, busy_vec[0] = 0. Repeat with HARDWIRE_ZERO=0: reads 32'hDEADBEEF.
- Bypass: read and write reg 12 = 32'hC0000000 in the same cycle. With FPRF_BYPASS_EN, rd_data = 32'hC0000000 that cycle. Without it, rd_data is the old value.

Source files
------------

// File: rtl/fprf_pkg.sv
// Shared constants, types and helpers for the floating-point register file
// and its scoreboard.
package fprf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Address width for a register count; never narrower than one bit.
    function automatic int fprf_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic addr_in_range(input int unsigned a, input int unsigned n);
        return a < n;
    endfunction

    typedef logic [XLEN_DEF-1:0]               fp_reg_t;
    typedef logic [fprf_aw(NREGS_DEF)-1:0]     fp_addr_t;

endpackage

// File: rtl/fprf_scoreboard.sv
// Busy-bit scoreboard: flush beats issue-set, issue-set beats write-back
// clear. Produces the combinational issue-ready handshake.
module fprf_scoreboard
    import fprf_pkg::*;
#(
    parameter int NREGS         = NREGS_DEF,
    parameter int NWR           = 2,
    parameter int HARDWIRE_ZERO = 1,
    localparam int AW           = fprf_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      wb_en,
    input  logic [NWR*AW-1:0]   wb_addr,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic                iss_ready,
    output logic [NREGS-1:0]    busy_vec
);

    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;
    logic             iss_hit;
    logic             iss_free;

    always_comb begin
        iss_hit = 1'b0;
        for (int k = 0; k < NWR; k++) begin
            if (wb_en[k] && wb_addr[k*AW +: AW] == iss_rd) begin
                iss_hit = 1'b1;
            end
        end
    end

    // Out-of-range and hardwired-zero destinations are never tracked.
    assign iss_free  = !addr_in_range(32'(iss_rd), NREGS)
                    || (HARDWIRE_ZERO != 0 && iss_rd == '0);
    assign iss_ready = iss_free || iss_hit || !busy_reg[iss_rd];

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
        if (HARDWIRE_ZERO != 0 && gi == 0) begin : g_zero
            assign busy_next[gi] = 1'b0;
        end else begin : g_track
            logic clr;
            logic set;
            always_comb begin
                clr = 1'b0;
                for (int k = 0; k < NWR; k++) begin
                    if (wb_en[k] && wb_addr[k*AW +: AW] == AW'(gi)) begin
                        clr = 1'b1;
                    end
                end
            end
            assign set = iss_valid && iss_ready && iss_rd == AW'(gi);
            assign busy_next[gi] = flush ? 1'b0 :
                                   set   ? 1'b1 :
                                   clr   ? 1'b0 : busy_reg[gi];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_vec = busy_reg;

endmodule

// File: rtl/fp_regfile_sb.sv
// FP register file with integrated busy scoreboard. Optional same-cycle
// write-to-read forwarding is enabled by defining FPRF_BYPASS_EN.
module fp_regfile_sb
    import fprf_pkg::*;
#(
    parameter int XLEN          = XLEN_DEF,
    parameter int NREGS         = NREGS_DEF,
    parameter int NRD           = 3,
    parameter int NWR           = 2,
    parameter int HARDWIRE_ZERO = 1,
    localparam int AW           = fprf_aw(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wb_en,
    input  logic [NWR*AW-1:0]     wb_addr,
    input  logic [NWR*XLEN-1:0]   wb_data,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    output logic                  iss_ready,
    input  logic                  flush,
    output logic [NREGS-1:0]      busy_vec
);

    logic [XLEN-1:0] mem [NREGS];
    logic [NWR-1:0]  wr_ok;

    for (genvar gi = 0; gi < NWR; gi++) begin : g_wr_ok
        logic [AW-1:0] wa;
        assign wa = wb_addr[gi*AW +: AW];
        assign wr_ok[gi] = wb_en[gi] && addr_in_range(32'(wa), NREGS)
                        && !(HARDWIRE_ZERO != 0 && wa == '0);
    end

    // Ports are scanned in ascending order so the highest index lands last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_ok[k]) begin
                    mem[wb_addr[k*AW +: AW]] <= wb_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] d;
        logic            b;
        assign ra = rd_addr[gi*AW +: AW];
        always_comb begin
            d = '0;
            b = 1'b0;
            if (addr_in_range(32'(ra), NREGS) && !(HARDWIRE_ZERO != 0 && ra == '0)) begin
                d = mem[ra];
                b = busy_vec[ra];
            end
`ifdef FPRF_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (wr_ok[k] && wb_addr[k*AW +: AW] == ra) begin
                    d = wb_data[k*XLEN +: XLEN];
                    b = 1'b0;
                end
            end
`endif
        end
        assign rd_data[gi*XLEN +: XLEN] = d;
        assign rd_busy[gi]              = b;
    end

    fprf_scoreboard #(
        .NREGS         (NREGS),
        .NWR           (NWR),
        .HARDWIRE_ZERO (HARDWIRE_ZERO)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .iss_ready (iss_ready),
        .busy_vec  (busy_vec)
    );

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Scoreboard-style bench for fp_regfile_sb: directed stimulus queues expected
// values, a negedge monitor pops and compares them against the DUT outputs.
module tb_fp_regfile_sb;

    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  ra [3];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [1:0]  wb_en = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        flush = 1'b0;

    logic [14:0] rd_addr;
    logic [9:0]  wb_addr;
    logic [63:0] wb_data;
    logic [95:0] rd_data, rd_data_z;
    logic [2:0]  rd_busy, rd_busy_z;
    logic        iss_ready, iss_ready_z;
    logic [31:0] busy_vec, busy_vec_z;

    assign rd_addr = {ra[2], ra[1], ra[0]};
    assign wb_addr = {wa[1], wa[0]};
    assign wb_data = {wd[1], wd[0]};

    always #5 clk = ~clk;

    fp_regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .flush(flush), .busy_vec(busy_vec)
    );

    fp_regfile_sb #(.HARDWIRE_ZERO(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_z),
        .rd_busy(rd_busy_z), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready_z),
        .flush(flush), .busy_vec(busy_vec_z)
    );

    localparam int S_RD0 = 0, S_RD1 = 1, S_RD2 = 2, S_BUSY0 = 3,
                   S_BVEC = 4, S_READY = 5, S_Z_RD0 = 6, S_Z_BVEC = 7;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t e;
    logic [31:0] act;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
                S_RD0:    act = rd_data[31:0];
                S_RD1:    act = rd_data[63:32];
                S_RD2:    act = rd_data[95:64];
                S_BUSY0:  act = {31'b0, rd_busy[0]};
                S_BVEC:   act = busy_vec;
                S_READY:  act = {31'b0, iss_ready};
                S_Z_RD0:  act = rd_data_z[31:0];
                default:  act = busy_vec_z;
            endcase
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end else begin
                $display("ok   %s: %h", e.name, act);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [31:0] v, input string name);
        exp_t x;
        x.sel = sel; x.exp = v; x.name = name;
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        wb_en = '0; iss_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
        wb_en[port] = 1'b1; wa[port] = a; wd[port] = d;
    endtask

    task automatic issue(input logic [4:0] a);
        iss_valid = 1'b1; iss_rd = a;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) ra[i] = '0;
        for (int i = 0; i < 2; i++) begin wa[i] = '0; wd[i] = '0; end
        step(); step();
        rst_n = 1'b1;
        ra[0] = 5; iss_rd = 5;
        expect_val(S_RD0,   32'h0, "reset_rd_data");
        expect_val(S_BVEC,  32'h0, "reset_busy_vec");
        expect_val(S_READY, 32'h1, "reset_iss_ready");

        // Write and claim reg 5, then reset asynchronously mid-cycle.
        step(); wr(0, 5, 32'h3F800000); issue(5);
        expect_val(S_READY, 32'h1, "iss5_ready");
        step();
        expect_val(S_RD0,  32'h3F800000, "reg5_written");
        expect_val(S_BVEC, 32'h00000020, "reg5_busy");
        step(); #1 rst_n = 1'b0; #1 rst_n = 1'b1;
        expect_val(S_RD0,  32'h0, "midrst_rd_data");
        expect_val(S_BVEC, 32'h0, "midrst_busy_vec");

        // Issue reg 7, write back two cycles later.
        step(); ra[0] = 7; issue(7);
        expect_val(S_BUSY0, 32'h0, "r7_busy_c0");
        step();
        expect_val(S_BUSY0, 32'h1, "r7_busy_c1");
        step(); wr(0, 7, 32'h40490FDB);
`ifdef FPRF_BYPASS_EN
        expect_val(S_BUSY0, 32'h0, "r7_busy_c2");
        expect_val(S_RD0,   32'h40490FDB, "r7_bypass_c2");
`else
        expect_val(S_BUSY0, 32'h1, "r7_busy_c2");
        expect_val(S_RD0,   32'h0, "r7_old_c2");
`endif
        step();
        expect_val(S_BUSY0, 32'h0, "r7_busy_c3");
        expect_val(S_RD0,   32'h40490FDB, "r7_data");

        // WAW stall on reg 3, then issue in the write-back cycle.
        step(); issue(3);
        step(); issue(3);
        expect_val(S_READY, 32'h0, "waw_stall");
        expect_val(S_BVEC,  32'h00000008, "waw_busy_vec");
        step(); wr(1, 3, 32'h12345678); issue(3);
        expect_val(S_READY, 32'h1, "waw_ready_on_wb");
        step(); ra[1] = 3;
        expect_val(S_BVEC, 32'h00000008, "set_beats_clr");
        expect_val(S_RD1,  32'h12345678, "set_clr_data");

        // Flush beats a simultaneous issue and keeps contents.
        step(); flush = 1'b1; issue(4);
        expect_val(S_READY, 32'h1, "flush_iss4_ready");
        step();
        expect_val(S_BVEC, 32'h0, "flush_busy_vec");
        expect_val(S_RD1,  32'h12345678, "flush_keeps_data");

        // Dual write collision on reg 9.
        step(); wr(0, 9, 32'h1); wr(1, 9, 32'h2);
        step(); ra[0] = 9;
        expect_val(S_RD0, 32'h2, "dual_write_hi_wins");

        // Zero register, hardwired and ordinary.
        step(); wr(0, 0, 32'hDEADBEEF); issue(0);
        expect_val(S_READY, 32'h1, "zero_iss_ready");
        step(); ra[0] = 0;
        expect_val(S_RD0,    32'h0, "zero_hw_read");
        expect_val(S_BVEC,   32'h0, "zero_hw_busy");
        expect_val(S_Z_RD0,  32'hDEADBEEF, "zero_plain_read");
        expect_val(S_Z_BVEC, 32'h00000001, "zero_plain_busy");

        // Same-cycle read/write of reg 12.
        step(); wr(0, 12, 32'h11111111);
        step(); ra[2] = 12; wr(0, 12, 32'hC0000000);
`ifdef FPRF_BYPASS_EN
        expect_val(S_RD2, 32'hC0000000, "bypass_same_cycle");
`else
        expect_val(S_RD2, 32'h11111111, "nobypass_same_cycle");
`endif
        step();
        expect_val(S_RD2, 32'hC0000000, "r12_after");

        step(); step();
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
